// File: rtl/pet2001keys_uart_if.sv
// Keyboard-matrix and UART-TX signal bundle for pet2001keys_uart.
// master: the scanner side (drives rows, sends bytes).
// slave:  the board/UART side (drives columns and busy).
interface pet2001keys_uart_if;
  logic [3:0] keyrow;
  logic [7:0] keycol;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_busy;

  modport master (
    output keyrow,
    output tx_data,
    output tx_strobe,
    input  keycol,
    input  tx_busy
  );

  modport slave (
    input  keyrow,
    input  tx_data,
    input  tx_strobe,
    output keycol,
    output tx_busy
  );
endinterface

// File: rtl/pet2001keys_uart.sv
// PET 2001 keyboard-matrix scanner feeding a UART transmitter.
// Rows 0..9 are driven for SCAN_CYCLES each and the active-low columns are
// sampled on the last cycle of the row. Two consecutive pressed samples make
// a key stable; only the lowest new key per row sample emits an ASCII byte,
// which goes through a FIFO_DEPTH-entry queue to a strobe/busy TX handshake.
// Optional macro PET2001_KEYS_SHIFT_EN: while a shift key is held, letters
// become lowercase and the 1/2/3 keys give ! " #.
module pet2001keys_uart #(
  parameter int SCAN_CYCLES = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  pet2001keys_uart_if.master bus
);
  localparam int            TW   = $clog2(SCAN_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(SCAN_CYCLES - 1);
  localparam int            PW   = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);

  // ASCII codes of one matrix row, column 0 in the top byte; 0x00 = no character.
  function automatic logic [63:0] row_map(input logic [3:0] row);
    case (row)
      4'd0:    row_map = 64'h21_23_25_26_28_5F_00_00;
      4'd1:    row_map = 64'h22_24_27_5C_29_00_00_08;
      4'd2:    row_map = 64'h51_45_54_55_4F_5E_37_39;
      4'd3:    row_map = 64'h57_52_59_49_50_00_38_2F;
      4'd4:    row_map = 64'h41_44_47_4A_4C_00_34_36;
      4'd5:    row_map = 64'h53_46_48_4B_3A_00_35_2A;
      4'd6:    row_map = 64'h5A_43_42_4D_3B_0D_31_33;
      4'd7:    row_map = 64'h58_56_4E_2C_3F_00_32_2B;
      4'd8:    row_map = 64'h00_40_5D_00_3E_00_30_2D;
      4'd9:    row_map = 64'h00_5B_20_3C_00_00_2E_3D;
      default: row_map = 64'h0;
    endcase
  endfunction

  logic [TW-1:0] r_timer;
  logic [3:0]    r_row;
  logic [7:0]    r_prev   [10];
  logic [7:0]    r_stable [10];
  logic          r_ev_vld;
  logic [7:0]    r_ev_code;
  logic [7:0]    r_mem    [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_tx_data;
  logic          r_tx_strobe;

  logic          w_sample;
  logic [7:0]    w_now;
  logic [7:0]    w_cand;
  logic [7:0]    w_pick;
  logic [2:0]    w_col;
  logic [63:0]   w_rowmap;
  logic [7:0]    w_code;
  logic          w_hit;
  logic          w_pop;
  logic          w_push;

  // Sample decode: candidate keys, lowest new key, its translated code.
  always_comb begin
    w_sample = (r_timer == LAST);
    w_now    = ~bus.keycol;
    w_cand   = w_now & r_prev[r_row] & ~r_stable[r_row];
    w_pick   = w_cand & (~w_cand + 8'd1);
    w_col    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_cand[i]) w_col = 3'(i);
    end
    w_rowmap = row_map(r_row);
    w_code   = w_rowmap[63 - 8*int'(w_col) -: 8];
`ifdef PET2001_KEYS_SHIFT_EN
    // Shift state is the debounced state before this sample is applied.
    if (r_stable[8][0] | r_stable[8][5]) begin
      if (w_code >= 8'h41 && w_code <= 8'h5A) w_code = w_code + 8'h20;
      else if ({r_row, w_col} == {4'd6, 3'd6}) w_code = 8'h21;
      else if ({r_row, w_col} == {4'd7, 3'd6}) w_code = 8'h22;
      else if ({r_row, w_col} == {4'd6, 3'd7}) w_code = 8'h23;
    end
`endif
    w_hit    = w_sample && (w_cand != 8'd0) && (w_code != 8'd0);
    w_pop    = (r_count != '0) && !bus.tx_busy && !r_tx_strobe;
    w_push   = r_ev_vld && ((r_count != FULL) || w_pop);
  end

  // Row timer and row select, wrapping 9 -> 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_row   <= 4'd0;
    end else if (w_sample) begin
      r_timer <= '0;
      r_row   <= (r_row == 4'd9) ? 4'd0 : r_row + 4'd1;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Per-key debounce: press needs two pressed samples, release two released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) begin
        r_prev[i]   <= 8'd0;
        r_stable[i] <= 8'd0;
      end
    end else if (w_sample) begin
      r_prev[r_row]   <= w_now;
      r_stable[r_row] <= (r_stable[r_row] & ~(~w_now & ~r_prev[r_row])) | w_pick;
    end
  end

  // Translation register: the event enqueues one cycle after the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ev_vld <= 1'b0;
    else        r_ev_vld <= w_hit;
  end

  // Translated byte travels alongside r_ev_vld.
  always_ff @(posedge clk) begin
    if (w_hit) r_ev_code <= w_code;
  end

  // FIFO pointers and occupancy; a full FIFO drops the new byte unless popping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_ev_code;
  end

  // TX handshake: one-cycle strobe, never back to back; data held until next strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_strobe <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_tx_strobe <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rptr];
    end
  end

  assign bus.keyrow    = r_row;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_strobe = r_tx_strobe;
endmodule

// File: tb/tb_pet2001keys_uart.sv
// Testbench for pet2001keys_uart: randomized and directed key presses on a
// modelled matrix, a behavioural keyboard/queue model, and a scoreboard
// monitor comparing every tx_strobe against the expected byte stream.
module tb_pet2001keys_uart;
  localparam int SC    = 4;
  localparam int DEPTH = 4;
  localparam int SCAN  = 10 * SC;

  // Key table, row-major (row*8 + col); 0 = no character.
  localparam logic [7:0] KMAP [80] = '{
    8'h21, 8'h23, 8'h25, 8'h26, 8'h28, 8'h5F, 8'h00, 8'h00,
    8'h22, 8'h24, 8'h27, 8'h5C, 8'h29, 8'h00, 8'h00, 8'h08,
    8'h51, 8'h45, 8'h54, 8'h55, 8'h4F, 8'h5E, 8'h37, 8'h39,
    8'h57, 8'h52, 8'h59, 8'h49, 8'h50, 8'h00, 8'h38, 8'h2F,
    8'h41, 8'h44, 8'h47, 8'h4A, 8'h4C, 8'h00, 8'h34, 8'h36,
    8'h53, 8'h46, 8'h48, 8'h4B, 8'h3A, 8'h00, 8'h35, 8'h2A,
    8'h5A, 8'h43, 8'h42, 8'h4D, 8'h3B, 8'h0D, 8'h31, 8'h33,
    8'h58, 8'h56, 8'h4E, 8'h2C, 8'h3F, 8'h00, 8'h32, 8'h2B,
    8'h00, 8'h40, 8'h5D, 8'h00, 8'h3E, 8'h00, 8'h30, 8'h2D,
    8'h00, 8'h5B, 8'h20, 8'h3C, 8'h00, 8'h00, 8'h2E, 8'h3D
  };

`ifdef PET2001_KEYS_SHIFT_EN
  localparam logic [7:0] SHIFT_A = 8'h61;
`else
  localparam logic [7:0] SHIFT_A = 8'h41;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pet2001keys_uart_if bus();
  pet2001keys_uart #(.SCAN_CYCLES(SC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] pressed [10];
  always_comb begin
    if (bus.keyrow < 4'd10) bus.keycol = ~pressed[bus.keyrow];
    else                    bus.keycol = 8'hFF;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q [$];
  bit         m_prev   [10][8];
  bit         m_stable [10][8];
  int         m_timer = 0;
  int         m_row   = 0;
  bit         pend    = 0;
  logic [7:0] pend_code;
  int         m_col;
  bit         m_now;
  logic [7:0] m_code;

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 8; c++) begin
          m_prev[r][c]   = 0;
          m_stable[r][c] = 0;
        end
      exp_q.delete();
      pend    = 0;
      m_timer = 0;
      m_row   = 0;
    end else begin
      if (pend) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pend_code);
        pend = 0;
      end
      if (m_timer == SC - 1) begin
        m_col = -1;
        for (int c = 0; c < 8; c++)
          if (m_col < 0 && pressed[m_row][c] && m_prev[m_row][c] && !m_stable[m_row][c]) m_col = c;
        if (m_col >= 0) begin
          m_code = KMAP[m_row*8 + m_col];
`ifdef PET2001_KEYS_SHIFT_EN
          if (m_stable[8][0] || m_stable[8][5]) begin
            if (m_code >= 8'h41 && m_code <= 8'h5A) m_code = m_code + 8'd32;
            else if (m_row == 6 && m_col == 6) m_code = 8'h21;
            else if (m_row == 7 && m_col == 6) m_code = 8'h22;
            else if (m_row == 6 && m_col == 7) m_code = 8'h23;
          end
`endif
          if (m_code != 8'h00) begin
            pend      = 1;
            pend_code = m_code;
          end
        end
        for (int c = 0; c < 8; c++) begin
          m_now = pressed[m_row][c];
          if (!m_now && !m_prev[m_row][c]) m_stable[m_row][c] = 0;
          if (c == m_col) m_stable[m_row][c] = 1;
          m_prev[m_row][c] = m_now;
        end
        m_timer = 0;
        m_row   = (m_row + 1) % 10;
      end else begin
        m_timer++;
      end
      check("keyrow", bus.keyrow, m_row);
    end
  end

  // ---------------- scoreboard monitor ----------------
  int         strobe_count = 0;
  logic [7:0] last_data    = 8'h00;
  bit         prev_strobe  = 0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      last_data   = 8'h00;
      prev_strobe = 0;
    end else if (bus.tx_strobe) begin
      check("strobe_while_busy", bus.tx_busy, 1'b0);
      check("strobe_back_to_back", prev_strobe, 1'b0);
      check("strobe_has_expected_byte", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("tx_data", bus.tx_data, exp_q.pop_front());
      last_data = bus.tx_data;
      strobe_count++;
      prev_strobe = 1;
    end else begin
      check("tx_data_hold", bus.tx_data, last_data);
      prev_strobe = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_key(input int r, input int c, input int n);
    pressed[r][c] = 1'b1;
    cyc(n);
    pressed[r][c] = 1'b0;
  endtask

  task automatic drain();
    int t;
    bus.tx_busy = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || pend) && t < 2000) begin
      cyc(1);
      t++;
    end
    cyc(SCAN);
    check("drain_empty", exp_q.size(), 0);
  endtask

  int cnt0;
  int kr [6] = '{4, 4, 2, 6, 9, 3};
  int kc [6] = '{0, 1, 0, 6, 2, 7};

  initial begin
    for (int r = 0; r < 10; r++) pressed[r] = 8'h00;
    bus.tx_busy = 1'b0;
    reset = 1'b0;
    cyc(3);
    check("reset_keyrow", bus.keyrow, 4'd0);
    check("reset_strobe", bus.tx_strobe, 1'b0);
    check("reset_tx_data", bus.tx_data, 8'h00);
    reset = 1'b1;

    // Row cadence: SC cycles per row, wrap after row 9.
    cyc(SC);
    check("keyrow_after_one_row", bus.keyrow, 4'd1);
    cyc(9 * SC);
    check("keyrow_wrap", bus.keyrow, 4'd0);

    // Single held key -> one 'A'.
    cnt0 = strobe_count;
    hold_key(4, 0, 3 * SCAN);
    cyc(3 * SCAN);
    drain();
    check("held_key_count", strobe_count - cnt0, 1);
    check("held_key_code", last_data, 8'h41);

    // Glitch of one sample, then two valid presses of space.
    cnt0 = strobe_count;
    hold_key(9, 2, SCAN);
    cyc(2 * SCAN);
    drain();
    check("glitch_count", strobe_count - cnt0, 0);
    hold_key(9, 2, 2 * SCAN);
    cyc(2 * SCAN);
    hold_key(9, 2, 2 * SCAN);
    cyc(2 * SCAN);
    drain();
    check("repress_count", strobe_count - cnt0, 2);
    check("space_code", last_data, 8'h20);

    // Same-row multi-press: 'A' then 'D' one scan later.
    cnt0 = strobe_count;
    pressed[4][0] = 1'b1;
    pressed[4][1] = 1'b1;
    cyc(4 * SCAN);
    pressed[4] = 8'h00;
    cyc(3 * SCAN);
    drain();
    check("multi_count", strobe_count - cnt0, 2);
    check("multi_last", last_data, 8'h44);

    // Overflow while busy: only the first DEPTH bytes survive.
    cnt0 = strobe_count;
    bus.tx_busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hold_key(kr[k], kc[k], 2 * SCAN);
      cyc(2 * SCAN);
    end
    check("overflow_no_strobe_while_busy", strobe_count - cnt0, 0);
    drain();
    check("overflow_count", strobe_count - cnt0, DEPTH);
    check("overflow_last", last_data, 8'h31);

    // Reset mid-row with two bytes queued.
    bus.tx_busy = 1'b1;
    hold_key(4, 0, 2 * SCAN);
    cyc(2 * SCAN);
    hold_key(4, 1, 2 * SCAN);
    cyc(2 * SCAN + SC / 2 + 1);
    reset = 1'b0;
    #1;
    check("midreset_keyrow", bus.keyrow, 4'd0);
    check("midreset_strobe", bus.tx_strobe, 1'b0);
    check("midreset_tx_data", bus.tx_data, 8'h00);
    cyc(3);
    reset = 1'b1;
    bus.tx_busy = 1'b0;
    cnt0 = strobe_count;
    cyc(5 * SCAN);
    check("after_reset_silent", strobe_count - cnt0, 0);
    hold_key(6, 5, 2 * SCAN);
    cyc(2 * SCAN);
    drain();
    check("after_reset_count", strobe_count - cnt0, 1);
    check("after_reset_code", last_data, 8'h0D);

    // Shift held, then 'A'.
    cnt0 = strobe_count;
    pressed[8][0] = 1'b1;
    cyc(3 * SCAN);
    hold_key(4, 0, 3 * SCAN);
    pressed[8][0] = 1'b0;
    cyc(3 * SCAN);
    drain();
    check("shift_count", strobe_count - cnt0, 1);
    check("shift_code", last_data, SHIFT_A);

    // Randomized presses, releases and busy periods.
    for (int it = 0; it < 60; it++) begin
      pressed[$urandom_range(9)][$urandom_range(7)] = 1'b1;
      if ($urandom_range(3) == 0) pressed[$urandom_range(9)] = 8'h00;
      if ($urandom_range(4) == 0) for (int r = 0; r < 10; r++) pressed[r] = 8'h00;
      bus.tx_busy = ($urandom_range(2) == 0);
      cyc($urandom_range(1, 25) * SC + $urandom_range(SC - 1));
    end
    for (int r = 0; r < 10; r++) pressed[r] = 8'h00;
    cyc(3 * SCAN);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pet2001keys_uart.md
Name: pet2001keys_uart

Overview:
- Scans a physical PET 2001 keyboard matrix and converts debounced key presses into ASCII bytes for a UART transmitter. This is the reverse of the UART-to-key-press injector path.
- Drives the 4-bit row select, samples the 8 active-low column lines, detects newly pressed keys, and translates (row,col) to ASCII.
- Queues characters in a small FIFO and hands them to the UART TX with a strobe/busy handshake.

Parameters:
- SCAN_CYCLES, 5000, clock cycles each row is driven before sampling (100 us at 50 MHz); minimum 2.
- FIFO_DEPTH, 4, character queue depth; power of two, 2..16.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- keyrow  output  4  matrix row select, 0..9.
- keycol  input  8  column lines for the selected row; 0 = pressed.
- tx_data  output  8  ASCII byte to UART TX; valid while tx_strobe is high.
- tx_strobe  output  1  one-cycle send request.
- tx_busy  input  1  UART TX busy; no strobe is issued while it is high.

Behaviour:
- Reset (reset=0, async): keyrow=0, tx_strobe=0, tx_data=0x00, FIFO empty, all key state cleared, row timer=0.
- Scan: keyrow holds each row for SCAN_CYCLES cycles. keycol is sampled on the last cycle of the row. keyrow then advances; after 9 it wraps to 0. A full scan takes 10*SCAN_CYCLES cycles.
- Per-key state (80 bits each): prev = pressed at the previous sample of this row; stable = debounced pressed.
- At each row sample, with now = ~keycol:
  - cand = now & prev[row] & ~stable[row].
  - Only the lowest-indexed set bit of cand becomes stable this sample and generates an event. Other cand bits stay unstable and are picked up on later scans (at most one event per row sample).
  - Release: stable bits where ~now & ~prev[row] are cleared.
  - prev[row] <= now.
- Debounce therefore needs two consecutive samples pressed to register a press, and two consecutive samples released to register a release. A held key generates no repeat events.
- Translation: (row,col) maps to ASCII per the PET 2001 graphics-keyboard table in the team keyboard doc. Where several ASCII codes map to one position, the unshifted (uppercase) code is used. Examples: (4,0)=0x41 'A', (9,2)=0x20, (6,5)=0x0D, (8,6)=0x30, (1,7)=0x08, (3,7)=0x2F.
- Shift positions (8,0) and (8,5), and any unmapped position, never generate a character but are still debounced and tracked.
- An event enqueues its byte the cycle after the sample (1-cycle translation register).
- FIFO full on enqueue: the new byte is dropped and the key still becomes stable (no retry). The FIFO never overwrites existing entries.
- Transmit: tx_strobe=1 for one cycle when the FIFO is non-empty, tx_busy=0, and tx_strobe was 0 in the previous cycle. tx_data = FIFO head, and the head is popped that cycle.
  - tx_strobe is never high in two consecutive cycles, which absorbs one cycle of tx_busy latency.
  - tx_data holds its value until the next strobe.
- Simultaneous enqueue and pop: both take effect; count is unchanged; a full FIFO accepts the byte.
- Reset mid-scan or mid-transmit: everything clears asynchronously; a pending character is lost and no strobe is issued until after reset release.

Optional Feature:
- Macro: PET2001_KEYS_SHIFT_EN.
- Defined: the block tracks whether either shift position is stable-pressed at the moment an event is translated. If so:
  - letters 0x41..0x5A become lowercase 0x61..0x7A;
  - digit row (6,6),(7,6),(6,7) gives 0x21,0x22,0x23;
  - all other codes are unchanged.
- Not defined: shift state is ignored and the output is always the unshifted code.

Test Plan:
- SCAN_CYCLES=4: hold row 4 col 0 low for 3 full scans, tx_busy=0 -> exactly one tx_strobe with tx_data=0x41, and keyrow cycles 0..9 with 4 cycles per row.
- Glitch: hold (9,2) pressed for one row sample only -> no strobe. Hold it for two consecutive samples -> one strobe with 0x20. Release then re-press with two samples each -> a second 0x20.
- Same-row multi-press: (4,0) and (4,1) pressed together -> 0x41 first, then 0x44 one scan later. No strobes in consecutive cycles.
- FIFO overflow, FIFO_DEPTH=4, tx_busy=1: press 6 distinct mapped keys -> after tx_busy=0, exactly 4 strobes with the first 4 codes in press order.
- Reset asserted low mid-row with FIFO holding 2 bytes -> keyrow=0, tx_strobe=0 immediately, and no output after release until new presses.
- With PET2001_KEYS_SHIFT_EN: hold (8,0), then press (4,0) -> 0x61, with no byte for the shift key. Without the macro -> 0x41.
